// File: rtl/speed_pause_if.sv
// Button inputs and speed-select outputs of the speed/pause controller.
// The master side drives raw buttons; the slave side is the controller.
interface speed_pause_if;
    logic       btn_up;
    logic       btn_down;
    logic       btn_pause;
    logic [1:0] sel;
    logic       en;
    logic [1:0] speed;
    logic       paused;
    logic       busy;

    modport master (
        output btn_up, btn_down, btn_pause,
        input  sel, en, speed, paused, busy
    );

    modport slave (
        input  btn_up, btn_down, btn_pause,
        output sel, en, speed, paused, busy
    );
endinterface

// File: rtl/speed_pause_ctrl.sv
// Debounced up/down/pause buttons steering a 4:1 clock-enable mux select,
// with an en-low gap around every select change so the mux never glitches.
//
//   state   | meaning
//   --------+----------------------------------------------------
//   RUN     | mux enabled, sel == speed, accepting up/down/pause
//   GAP     | mux disabled for GAP_CYCLES before the new sel
//   APPLY   | new sel/speed committed, mux still disabled
//   PAUSED  | mux disabled, up/down change sel/speed directly
module speed_pause_ctrl #(
    parameter int DEB_CYCLES = 50000,
    parameter int GAP_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    speed_pause_if.slave bus
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {S_RUN, S_GAP, S_APPLY, S_PAUSED} state_t;

    logic [2:0] w_raw;
    logic [2:0] w_ev;

    assign w_raw = {bus.btn_pause, bus.btn_down, bus.btn_up};

    // Synchronizers reset to 1 so a button held through reset is seen as
    // pressed and must be released (arming it) before it can raise an event.
    for (genvar g = 0; g < 3; g++) begin : g_btn
        logic          r_s1;
        logic          r_s2;
        logic          r_deb;
        logic          r_deb_d;
        logic          r_arm;
        logic [DW-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1    <= 1'b1;
                r_s2    <= 1'b1;
                r_deb   <= 1'b0;
                r_deb_d <= 1'b0;
                r_arm   <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_s1    <= w_raw[g];
                r_s2    <= r_s1;
                r_deb_d <= r_deb;
                if (!r_s2 && !r_deb)
                    r_arm <= 1'b1;
                if (r_s2 != r_deb) begin
                    if (r_cnt == DW'(DEB_CYCLES - 1)) begin
                        r_deb <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + DW'(1);
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end

        assign w_ev[g] = r_deb & ~r_deb_d & r_arm;
    end

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_speed, w_speed_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic [1:0]    r_target, w_target_nxt;
    logic [GW-1:0] r_gap_cnt, w_gap_nxt;
    logic          r_en, r_paused, r_busy;
    logic          w_up, w_down, w_pause, w_step;
    logic [1:0]    w_adj;

    // Up and down together cancel; pause priority comes from the case order.
    assign w_up    = w_ev[0] & ~w_ev[1];
    assign w_down  = w_ev[1] & ~w_ev[0];
    assign w_pause = w_ev[2];
    assign w_step  = (w_up && r_speed != 2'd3) || (w_down && r_speed != 2'd0);
    assign w_adj   = w_up ? r_speed + 2'd1 : r_speed - 2'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_speed_nxt  = r_speed;
        w_sel_nxt    = r_sel;
        w_target_nxt = r_target;
        w_gap_nxt    = r_gap_cnt;
        case (r_state)
            S_RUN: begin
                if (w_pause) begin
                    w_state_nxt = S_PAUSED;
                end else if (w_step) begin
                    w_target_nxt = w_adj;
                    w_gap_nxt    = GW'(GAP_CYCLES - 1);
                    w_state_nxt  = S_GAP;
                end
            end
            S_GAP: begin
                if (w_pause) begin
                    w_speed_nxt = r_target;
                    w_sel_nxt   = r_target;
                    w_state_nxt = S_PAUSED;
                end else if (r_gap_cnt == '0) begin
                    w_speed_nxt = r_target;
                    w_sel_nxt   = r_target;
                    w_state_nxt = S_APPLY;
                end else begin
                    w_gap_nxt = r_gap_cnt - GW'(1);
                end
            end
            S_APPLY: begin
                if (w_pause) begin
                    w_speed_nxt = r_target;
                    w_sel_nxt   = r_target;
                    w_state_nxt = S_PAUSED;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_PAUSED: begin
                if (w_pause) begin
                    w_state_nxt = S_RUN;
                end else if (w_step) begin
                    w_speed_nxt = w_adj;
                    w_sel_nxt   = w_adj;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_RUN;
            r_speed   <= 2'd0;
            r_sel     <= 2'd0;
            r_target  <= 2'd0;
            r_gap_cnt <= '0;
            r_en      <= 1'b0;
            r_paused  <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_speed   <= w_speed_nxt;
            r_sel     <= w_sel_nxt;
            r_target  <= w_target_nxt;
            r_gap_cnt <= w_gap_nxt;
            r_en      <= (w_state_nxt == S_RUN);
            r_paused  <= (w_state_nxt == S_PAUSED);
            r_busy    <= (w_state_nxt == S_GAP) || (w_state_nxt == S_APPLY);
        end
    end

    assign bus.sel    = r_sel;
    assign bus.en     = r_en;
    assign bus.speed  = r_speed;
    assign bus.paused = r_paused;
    assign bus.busy   = r_busy;
endmodule

// File: tb/tb_speed_pause_ctrl.sv
// Directed bench for speed_pause_ctrl with a cycle-level behavioural model
// compared every cycle, plus hand-computed checkpoints.
module tb_speed_pause_ctrl;
    localparam int DEB = 4;
    localparam int GAP = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    speed_pause_if bus ();

    speed_pause_ctrl #(.DEB_CYCLES(DEB), .GAP_CYCLES(GAP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: raw -> 2-sample delay -> debounce -> rising-edge events -> mode rules.
    logic [2:0] m_h0, m_h1, m_deb, m_rose, m_arm;
    int         m_run [3];
    int         m_speed, m_sel, m_target, m_left, m_mode;  // mode 0 run, 1 changing, 2 paused
    logic       m_en;

    task automatic model_reset();
        m_h0 = 3'b111; m_h1 = 3'b111; m_deb = 3'b000; m_rose = 3'b000; m_arm = 3'b000;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
        m_speed = 0; m_sel = 0; m_target = 0; m_left = 0; m_mode = 0; m_en = 1'b0;
    endtask

    initial begin
        logic [2:0] raw, ev;
        logic       smp;
        int         nxt;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                raw = {bus.btn_pause, bus.btn_down, bus.btn_up};
                ev  = m_rose & m_arm;
                for (int i = 0; i < 3; i++) begin
                    smp       = m_h1[i];
                    m_rose[i] = 1'b0;
                    if (!smp && !m_deb[i]) m_arm[i] = 1'b1;
                    if (smp != m_deb[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB) begin
                            m_deb[i]  = smp;
                            m_run[i]  = 0;
                            m_rose[i] = smp;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_h1 = m_h0;
                m_h0 = raw;
                if (m_mode == 0) m_en = 1'b1;
                if (ev[2]) begin
                    if (m_mode == 2) begin
                        m_mode = 0; m_en = 1'b1;
                    end else begin
                        if (m_mode == 1) begin m_speed = m_target; m_sel = m_target; end
                        m_mode = 2; m_en = 1'b0;
                    end
                end else if (m_mode == 1) begin
                    m_left--;
                    if (m_left == 1) begin m_speed = m_target; m_sel = m_target; end
                    if (m_left == 0) begin m_mode = 0; m_en = 1'b1; end
                end else if (ev[0] ^ ev[1]) begin
                    nxt = ev[0] ? m_speed + 1 : m_speed - 1;
                    if (nxt > 3) nxt = 3;
                    if (nxt < 0) nxt = 0;
                    if (nxt != m_speed) begin
                        if (m_mode == 2) begin
                            m_speed = nxt; m_sel = nxt;
                        end else begin
                            m_mode = 1; m_target = nxt; m_left = GAP + 1; m_en = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [6:0] act, exp;
        forever begin
            @(negedge clk);
            act = {bus.sel, bus.en, bus.speed, bus.paused, bus.busy};
            exp = {2'(m_sel), m_en, 2'(m_speed), (m_mode == 2), (m_mode == 1)};
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: got sel/en/speed/paused/busy=%b expected %b", $time, act, exp);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input logic [2:0] m, input int hold, input int idle,
                         output int en_lo, output int busy_hi);
        en_lo = 0;
        busy_hi = 0;
        {bus.btn_pause, bus.btn_down, bus.btn_up} = m;
        for (int i = 0; i < hold + idle; i++) begin
            if (i == hold) {bus.btn_pause, bus.btn_down, bus.btn_up} = 3'b000;
            tick(1);
            if (!bus.en) en_lo++;
            if (bus.busy) busy_hi++;
        end
    endtask

    initial begin
        int en_lo, busy_hi, found;
        bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.btn_pause = 1'b0;
        tick(3);
        check("reset_en", bus.en, 0);
        check("reset_sel", bus.sel, 0);
        check("reset_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick(1);
        check("first_cycle_en", bus.en, 1);
        tick(3);

        press(3'b001, 3, 12, en_lo, busy_hi);
        check("glitch_en_low", en_lo, 0);
        check("glitch_sel", bus.sel, 0);

        press(3'b001, 10, 12, en_lo, busy_hi);
        check("up1_en_low_cycles", en_lo, 3);
        check("up1_busy_cycles", busy_hi, 3);
        check("up1_speed", bus.speed, 1);
        check("up1_sel", bus.sel, 1);
        check("up1_en", bus.en, 1);

        press(3'b001, 10, 12, en_lo, busy_hi);
        press(3'b001, 10, 12, en_lo, busy_hi);
        check("up3_speed", bus.speed, 3);
        press(3'b001, 10, 12, en_lo, busy_hi);
        check("sat_busy_cycles", busy_hi, 0);
        check("sat_speed", bus.speed, 3);

        press(3'b100, 10, 12, en_lo, busy_hi);
        check("pause_paused", bus.paused, 1);
        check("pause_en", bus.en, 0);
        press(3'b010, 10, 12, en_lo, busy_hi);
        check("paused_down_en_low", en_lo, 22);
        check("paused_down_busy", busy_hi, 0);
        check("paused_down_speed", bus.speed, 2);
        check("paused_down_sel", bus.sel, 2);
        press(3'b100, 10, 12, en_lo, busy_hi);
        check("resume_en", bus.en, 1);
        check("resume_paused", bus.paused, 0);

        press(3'b101, 10, 12, en_lo, busy_hi);
        check("up_pause_paused", bus.paused, 1);
        check("up_pause_speed", bus.speed, 2);
        press(3'b100, 10, 12, en_lo, busy_hi);
        press(3'b011, 10, 12, en_lo, busy_hi);
        check("up_down_busy", busy_hi, 0);
        check("up_down_speed", bus.speed, 2);

        bus.btn_up = 1'b1;
        tick(2);
        bus.btn_pause = 1'b1;
        tick(10);
        bus.btn_up = 1'b0; bus.btn_pause = 1'b0;
        tick(12);
        check("gap_pause_paused", bus.paused, 1);
        check("gap_pause_speed", bus.speed, 3);
        check("gap_pause_sel", bus.sel, 3);
        press(3'b100, 10, 12, en_lo, busy_hi);
        check("gap_pause_resume_en", bus.en, 1);

        bus.btn_down = 1'b1;
        found = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (bus.busy) begin
                found = 1;
                break;
            end
        end
        check("gap_reached", found, 1);
        rst_n = 1'b0;
        bus.btn_down = 1'b0;
        #1;
        check("rst_gap_en", bus.en, 0);
        check("rst_gap_sel", bus.sel, 0);
        check("rst_gap_speed", bus.speed, 0);
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst_gap_release_en", bus.en, 1);
        check("rst_gap_release_sel", bus.sel, 0);
        tick(12);

        rst_n = 1'b0;
        bus.btn_up = 1'b1;
        tick(3);
        rst_n = 1'b1;
        press(3'b001, 15, 12, en_lo, busy_hi);
        check("held_in_reset_busy", busy_hi, 0);
        check("held_in_reset_speed", bus.speed, 0);
        press(3'b001, 10, 12, en_lo, busy_hi);
        check("repress_speed", bus.speed, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
